// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared interrupt-source encodings, FSM states and default vector ADL bytes
package int_ctrl_pkg;
  typedef enum logic [1:0] {
    INT_NONE = 2'd0,
    INT_IRQ  = 2'd1,
    INT_NMI  = 2'd2,
    INT_RES  = 2'd3
  } int_src_e;
  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } int_state_e;
  localparam logic [7:0] NMI_VEC_DEF = 8'hFA;
  localparam logic [7:0] RES_VEC_DEF = 8'hFC;
  localparam logic [7:0] IRQ_VEC_DEF = 8'hFE;
endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: control-side handshake between the 6502 control FSM and int_ctrl
//   inputs to int_ctrl : rdy, sync, handle_int, i_flag, nmi_n, irq_n
//   outputs of int_ctrl: interrupt, int_src[1:0], int_vec_adl[7:0], nmi_pending, irq_active
interface int_ctrl_if;
  logic       rdy;
  logic       sync;
  logic       handle_int;
  logic       i_flag;
  logic       nmi_n;
  logic       irq_n;
  logic       interrupt;
  logic [1:0] int_src;
  logic [7:0] int_vec_adl;
  logic       nmi_pending;
  logic       irq_active;
  modport master (
    output rdy, sync, handle_int, i_flag, nmi_n, irq_n,
    input  interrupt, int_src, int_vec_adl, nmi_pending, irq_active
  );
  modport slave (
    input  rdy, sync, handle_int, i_flag, nmi_n, irq_n,
    output interrupt, int_src, int_vec_adl, nmi_pending, irq_active
  );
endinterface

// File: rtl/int_ctrl_sync.sv
// int_sync: STAGES-flop synchroniser for an async active-low pin with falling-edge flag
//   clk, rst : clock, sync active-high reset (all flops reset to 1 = pin inactive)
//   d_i      : async pin
//   q_o      : synchronised level
//   fall_o   : 1 for one cycle when the synchronised level goes 1->0
module int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign q_o    = sync_q[STAGES-1];
  assign fall_o = prev_q & ~q_o;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: 6502 interrupt responder - syncs nmi_n/irq_n, commits at sync, supplies vector ADL
//   clk, rst : clock, sync active-high reset (starts a reset-vector sequence)
//   bus      : int_ctrl_if.slave (rdy, sync, handle_int, i_flag, nmi_n, irq_n in;
//              interrupt, int_src, int_vec_adl, nmi_pending, irq_active out)
//   NMI_HIJACK_EN: when defined, an NMI edge redirects an IRQ/BRK sequence to the NMI vector
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] NMI_VEC     = NMI_VEC_DEF,
  parameter logic [7:0] RES_VEC     = RES_VEC_DEF,
  parameter logic [7:0] IRQ_VEC     = IRQ_VEC_DEF
) (
  input logic        clk,
  input logic        rst,
  int_ctrl_if.slave  bus
);
`ifdef NMI_HIJACK_EN
  localparam bit HIJACK = 1'b1;
`else
  localparam bit HIJACK = 1'b0;
`endif
  int_state_e state_q, state_d;
  int_src_e   src_q, src_d;
  logic [7:0] vec_q, vec_d;
  logic       pend_q, pend_d;
  logic       nmi_s, nmi_fall, irq_s, irq_fall_unused;
  logic       irq_act, commit, ack, brk_clr, hij;
  int_sync #(.STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk(clk), .rst(rst), .d_i(bus.nmi_n), .q_o(nmi_s), .fall_o(nmi_fall)
  );
  int_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .clk(clk), .rst(rst), .d_i(bus.irq_n), .q_o(irq_s), .fall_o(irq_fall_unused)
  );
  assign irq_act = ~irq_s & ~bus.i_flag;
  always_comb begin
    commit  = (state_q == IDLE) & bus.sync & bus.rdy & (pend_q | irq_act);
    ack     = (state_q == SEQ) & bus.handle_int & bus.rdy;
    // BRK opcode caught by a pending NMI: its vector fetch services the NMI
    brk_clr = HIJACK & (state_q == IDLE) & bus.handle_int & bus.rdy & pend_q & ~commit;
    hij     = HIJACK & (state_q == SEQ) & ~ack & (src_q == INT_IRQ) & nmi_fall;
    // a fresh edge always wins over the clear from an ack in the same cycle
    pend_d  = nmi_fall | (pend_q & ~(ack & (src_q == INT_NMI)) & ~brk_clr);
    state_d = commit ? SEQ : ack ? IDLE : state_q;
    src_d   = commit ? (pend_q ? INT_NMI : INT_IRQ) : ack ? INT_NONE : hij ? INT_NMI : src_q;
    vec_d   = commit ? (pend_q ? NMI_VEC : IRQ_VEC) : hij ? NMI_VEC :
              (state_d == IDLE) ? ((HIJACK & pend_d) ? NMI_VEC : IRQ_VEC) : vec_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ;
      src_q   <= INT_RES;
      vec_q   <= RES_VEC;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      vec_q   <= vec_d;
      pend_q  <= pend_d;
    end
  end
  assign bus.interrupt   = (state_q == SEQ);
  assign bus.int_src     = src_q;
  assign bus.int_vec_adl = vec_q;
  assign bus.nmi_pending = pend_q;
  assign bus.irq_active  = irq_act;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl
module tb_int_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int_ctrl_if bus();
  int_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic irq_o, input logic [1:0] src, input logic [7:0] vec);
    chk({tag, ".interrupt"}, {31'd0, bus.interrupt}, {31'd0, irq_o});
    chk({tag, ".src"}, {30'd0, bus.int_src}, {30'd0, src});
    chk({tag, ".vec"}, {24'd0, bus.int_vec_adl}, {24'd0, vec});
  endtask
  initial begin
    bus.rdy = 1'b1; bus.sync = 1'b0; bus.handle_int = 1'b0;
    bus.i_flag = 1'b1; bus.nmi_n = 1'b1; bus.irq_n = 1'b1;
    tick(2);
    chk_out("reset", 1'b1, 2'd3, 8'hFC);
    chk("reset.pend", {31'd0, bus.nmi_pending}, 32'd0);
    chk("reset.irqact", {31'd0, bus.irq_active}, 32'd0);
    rst = 1'b0; bus.sync = 1'b1;
    tick(3);
    chk_out("res_seq_hold", 1'b1, 2'd3, 8'hFC);
    bus.sync = 1'b0; bus.handle_int = 1'b1;
    tick();
    bus.handle_int = 1'b0;
    chk_out("res_ack", 1'b0, 2'd0, 8'hFE);
    bus.handle_int = 1'b1;
    tick();
    bus.handle_int = 1'b0;
    chk_out("brk_idle", 1'b0, 2'd0, 8'hFE);
    // NMI edge latency: 3 edges after the pin falls
    bus.nmi_n = 1'b0;
    tick(2);
    chk("nmi_lat2", {31'd0, bus.nmi_pending}, 32'd0);
    tick();
    chk("nmi_lat3", {31'd0, bus.nmi_pending}, 32'd1);
    tick();
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    chk_out("nmi_commit", 1'b1, 2'd2, 8'hFA);
    bus.handle_int = 1'b1;
    tick();
    bus.handle_int = 1'b0;
    chk("nmi_ack.pend", {31'd0, bus.nmi_pending}, 32'd0);
    chk_out("nmi_ack", 1'b0, 2'd0, 8'hFE);
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    chk("nmi_level_no_retrig", {31'd0, bus.interrupt}, 32'd0);
    bus.nmi_n = 1'b1;
    // IRQ masked by I, then unmasked
    bus.irq_n = 1'b0;
    tick(3);
    bus.sync = 1'b1;
    tick(3);
    chk("irq_masked", {31'd0, bus.interrupt}, 32'd0);
    chk("irq_masked.act", {31'd0, bus.irq_active}, 32'd0);
    bus.i_flag = 1'b0;
    #1;
    chk("irq_unmasked.act", {31'd0, bus.irq_active}, 32'd1);
    tick();
    bus.sync = 1'b0;
    chk_out("irq_commit", 1'b1, 2'd1, 8'hFE);
    bus.irq_n = 1'b1; bus.i_flag = 1'b1;
    tick(3);
    chk_out("irq_deassert_hold", 1'b1, 2'd1, 8'hFE);
    bus.handle_int = 1'b1;
    tick();
    bus.handle_int = 1'b0;
    chk("irq_ack", {31'd0, bus.interrupt}, 32'd0);
    // IRQ and NMI together: NMI first, then IRQ
    bus.irq_n = 1'b0; bus.i_flag = 1'b0; bus.nmi_n = 1'b0;
    tick(4);
    chk("both.pend", {31'd0, bus.nmi_pending}, 32'd1);
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    chk_out("both_nmi", 1'b1, 2'd2, 8'hFA);
    bus.handle_int = 1'b1;
    tick();
    bus.handle_int = 1'b0;
    chk("both_ack.pend", {31'd0, bus.nmi_pending}, 32'd0);
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    chk_out("both_irq", 1'b1, 2'd1, 8'hFE);
    bus.handle_int = 1'b1;
    tick();
    bus.handle_int = 1'b0;
    bus.irq_n = 1'b1; bus.i_flag = 1'b1; bus.nmi_n = 1'b1;
    tick(3);
    // rdy low blocks commit and ack
    bus.nmi_n = 1'b0;
    tick(3);
    bus.sync = 1'b1; bus.rdy = 1'b0;
    tick(2);
    chk("rdy_no_commit", {31'd0, bus.interrupt}, 32'd0);
    bus.rdy = 1'b1;
    tick();
    bus.sync = 1'b0;
    chk_out("rdy_commit", 1'b1, 2'd2, 8'hFA);
    bus.handle_int = 1'b1; bus.rdy = 1'b0;
    tick(2);
    chk("rdy_no_ack", {31'd0, bus.interrupt}, 32'd1);
    chk("rdy_no_ack.pend", {31'd0, bus.nmi_pending}, 32'd1);
    bus.rdy = 1'b1;
    tick();
    bus.handle_int = 1'b0;
    chk("rdy_ack", {31'd0, bus.interrupt}, 32'd0);
    chk("rdy_ack.pend", {31'd0, bus.nmi_pending}, 32'd0);
    bus.nmi_n = 1'b1;
    tick(3);
    // NMI edge arriving during an IRQ sequence
    bus.irq_n = 1'b0; bus.i_flag = 1'b0;
    tick(2);
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    chk_out("hj_irq_commit", 1'b1, 2'd1, 8'hFE);
    bus.nmi_n = 1'b0;
    tick(3);
    chk("hj.pend", {31'd0, bus.nmi_pending}, 32'd1);
`ifdef NMI_HIJACK_EN
    chk_out("hj_switch", 1'b1, 2'd2, 8'hFA);
`else
    chk_out("hj_frozen", 1'b1, 2'd1, 8'hFE);
`endif
    bus.irq_n = 1'b1; bus.i_flag = 1'b1;
    bus.handle_int = 1'b1;
    tick();
    bus.handle_int = 1'b0;
    chk("hj_ack", {31'd0, bus.interrupt}, 32'd0);
`ifdef NMI_HIJACK_EN
    chk("hj_ack.pend", {31'd0, bus.nmi_pending}, 32'd0);
`else
    chk("hj_ack.pend", {31'd0, bus.nmi_pending}, 32'd1);
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    chk_out("hj_late_nmi", 1'b1, 2'd2, 8'hFA);
    bus.handle_int = 1'b1;
    tick();
    bus.handle_int = 1'b0;
    chk("hj_late_ack.pend", {31'd0, bus.nmi_pending}, 32'd0);
`endif
    // reset mid-sequence discards pending NMI
    bus.nmi_n = 1'b1;
    tick(3);
    bus.nmi_n = 1'b0;
    tick(3);
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    chk_out("pre_rst", 1'b1, 2'd2, 8'hFA);
    bus.nmi_n = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("mid_rst", 1'b1, 2'd3, 8'hFC);
    chk("mid_rst.pend", {31'd0, bus.nmi_pending}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
